mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Parametrised multiply/divide unit for the pipelined MIPS core. It sits in the E stage beside the ALU and owns the HI/LO register pair. It executes mult/multu/div/divu as fixed-latency multi-cycle operations and reports busy to the hazard controller, which stalls D-stage MDU instructions. It serves mfhi/mflo/mthi/mtlo in a single cycle and supports cancellation of an in-flight operation on pipeline flush.

## Interface
Parameters:
- WIDTH, 32: operand and HI/LO width.
- MUL_CYCLES, 5: busy cycles for multiply-class ops; must be ≥1.
- DIV_CYCLES, 10: busy cycles for divide-class ops; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  E-stage instruction carries a valid MDU op this cycle.
- op  in  4  operation code from mdu_pkg.
- a  in  WIDTH  forwarded rs value.
- b  in  WIDTH  forwarded rt value.
- cancel  in  1  flush; aborts any in-flight op; also blocks a same-cycle start.
- busy  out  1  registered; high while a long op is in flight.
- rdata  out  WIDTH  combinational: HI when op=MFHI, LO when op=MFLO, else 0.
- hi, lo  out  WIDTH  current architectural HI/LO.

## Operation
- Opcodes:
  - NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - MADD=9, MADDU=10, MSUB=11, MSUBU=12 (config-dependent, see Configuration).
- States:
  - IDLE → BUSY on an accepted long op (1–4, 9–12).
  - BUSY → IDLE when the counter reaches 0, or on cancel.
- Accept rule: start & ~cancel & state==IDLE. A start in BUSY is illegal; the hazard controller prevents it. It is ignored and flagged by a bench assertion.
- On accept:
  - Result is computed into pending_hi/pending_lo.
  - Counter loads MUL_CYCLES-1 or DIV_CYCLES-1.
- In BUSY the counter decrements each cycle. On the cycle it equals 0, HI/LO ← pending and state returns to IDLE.
- Multiply: {HI,LO} = a*b, 2·WIDTH bits; signed for MULT, unsigned for MULTU.
- Divide:
  - LO = quotient, truncated toward zero. HI = remainder, which takes the sign of the dividend.
  - Signed MIN/−1 → LO=MIN, HI=0.
  - b==0 → op is accepted and busy runs full latency, but HI/LO are left unchanged.
- MTHI/MTLO: accepted only in IDLE. HI or LO ← a at the next edge; busy stays 0.
- MFHI/MFLO: pure reads with no state change. While busy, rdata returns the old HI/LO; the hazard controller must stall them.
- cancel in BUSY: state→IDLE and pending is discarded; HI/LO keep their old values. cancel also suppresses MTHI/MTLO that cycle.
- Reset: busy=0, state=IDLE, counter=0, hi=lo=0, pending=0. Takes effect immediately, including mid-operation.

## Timing
- Accept at edge t0 (long op):
  - busy=1 during cycles t0+1 … t0+N, where N = MUL_CYCLES or DIV_CYCLES.
  - At edge t0+N, HI/LO update and busy falls together.
  - The new value is visible from cycle t0+N+1.
- Back-to-back: a new start is accepted in the first cycle busy=0.
- MTHI/MTLO: write is visible 1 cycle after the accepting edge.
- rdata is combinational from op and the HI/LO registers, with zero latency.
- cancel on the same edge the counter hits 0: cancel wins, and HI/LO are unchanged.

## Configuration
- MDU_MADD_EN defined:
  - Ops 9–12 are accepted with MUL_CYCLES latency.
  - {HI,LO} ← {HI,LO} ± a*b, modulo 2^(2·WIDTH); signed/unsigned per opcode.
  - The accumulator base is HI/LO sampled at accept.
- Undefined: ops 9–12 are treated as NONE. They are not accepted, busy stays 0, and there is no state change.

## Structure
- mdu_pkg holds:
  - The op code enum (4-bit) and the is_long/is_mul/is_div helper constants.
  - Default latency constants.
- Sub-module mdu_calc: purely combinational. Inputs are op, a, b, hi, lo; outputs are the pending {hi,lo} and a div_by_zero flag.
- The top holds the FSM, counter, HI/LO and pending registers, and the cancel logic.

## Test plan
Benches use WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10.
- MULT, a=−3 (0xFFFFFFFD), b=7 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV, a=−7, b=2 → busy 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU a=100,b=0 after MTHI a=0x11, MTLO a=0x22 → busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- MULTU 0xFFFFFFFF×0xFFFFFFFF with cancel at busy cycle 3 → busy drops next edge; HI/LO keep prior values; new MTLO accepted the following cycle.
- Reset asserted (low) during DIV busy cycle 6 → busy=0, hi=lo=0 immediately; no late update after release.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU a=1,b=1 → after 5 cycles HI=1, LO=0. Without the macro: busy never rises, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
// Latency: n/a (definitions only).
// Backpressure: n/a. Optional feature: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU as long ops.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MDU_WIDTH_DEF      = 32;
    localparam int MDU_MUL_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF = 10;

    // Multiply-class ops, including the accumulate forms when they are built in.
    function automatic logic is_mul(input logic [3:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_long(input logic [3:0] op);
        return is_mul(op) || is_div(op);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: next {hi,lo} for a long MDU op plus a divide-by-zero flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; result is captured by the top on accept. Accumulate ops need MDU_MADD_EN.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEF
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [W2-1:0]    a_sx, b_sx, a_zx, b_zx;
    logic [W2-1:0]    prod_s, prod_u, acc, result;
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag, bs_div, bu_div;
    logic [WIDTH-1:0] qs_mag, rs_mag, qs, rs, qu, ru;

    // Low 2W bits of the product of sign-extended operands equal the signed product.
    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zx   = {{WIDTH{1'b0}}, a};
    assign b_zx   = {{WIDTH{1'b0}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;
    assign acc    = {hi, lo};

    // Signed divide on magnitudes; MIN's magnitude is exact as an unsigned value,
    // so MIN/-1 naturally wraps back to MIN with remainder 0.
    assign b_zero = (b == '0);
    assign a_neg  = a[WIDTH-1];
    assign b_neg  = b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    // Divisor forced to 1 on zero only to keep the divider well-defined; result is unused then.
    assign bs_div = b_zero ? ONE : b_mag;
    assign bu_div = b_zero ? ONE : b;
    assign qs_mag = a_mag / bs_div;
    assign rs_mag = a_mag % bs_div;
    assign qs     = (a_neg ^ b_neg) ? -qs_mag : qs_mag;
    assign rs     = a_neg ? -rs_mag : rs_mag;
    assign qu     = a / bu_div;
    assign ru     = a % bu_div;

    assign div_by_zero = is_div(op) && b_zero;

    // Select the 2W-bit result; anything not producing a result passes HI/LO through.
    always_comb begin
        result = acc;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   if (!b_zero) result = {rs, qs};
            OP_DIVU:  if (!b_zero) result = {ru, qu};
`ifdef MDU_MADD_EN
            OP_MADD:  result = acc + prod_s;
            OP_MADDU: result = acc + prod_u;
            OP_MSUB:  result = acc - prod_s;
            OP_MSUBU: result = acc - prod_u;
`endif
            default:  result = acc;
        endcase
    end

    assign res_hi = result[W2-1:WIDTH];
    assign res_lo = result[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency long ops, single-cycle moves.
// Latency: MUL_CYCLES / DIV_CYCLES for long ops, 1 cycle for MTHI/MTLO, 0 for MFHI/MFLO reads.
// Backpressure: registered busy; caller must hold MDU ops while busy. cancel aborts. MDU_MADD_EN adds MADD/MSUB.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH      = MDU_WIDTH_DEF,
    parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    mdu_state_e       state;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] pend_hi, pend_lo;
    logic             pend_wr;
    logic [WIDTH-1:0] calc_hi, calc_lo;
    logic             calc_dz;
    logic             accept;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op          (op),
        .a           (a),
        .b           (b),
        .hi          (hi_q),
        .lo          (lo_q),
        .res_hi      (calc_hi),
        .res_lo      (calc_lo),
        .div_by_zero (calc_dz)
    );

    assign accept = start && !cancel && (state == ST_IDLE);

    // Control FSM: accept long ops into pending, count down, commit or discard; MT* writes in idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && is_long(op)) begin
                        pend_hi <= calc_hi;
                        pend_lo <= calc_lo;
                        pend_wr <= !calc_dz;
                        cnt     <= is_mul(op) ? CW'(MUL_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                        state   <= ST_BUSY;
                        busy_q  <= 1'b1;
                    end else if (accept && (op == OP_MTHI)) begin
                        hi_q <= a;
                    end else if (accept && (op == OP_MTLO)) begin
                        lo_q <= a;
                    end
                end
                ST_BUSY: begin
                    if (cancel) begin
                        // Flush beats completion even on the final count.
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt     <= '0;
                        pend_hi <= '0;
                        pend_lo <= '0;
                        pend_wr <= 1'b0;
                    end else if (cnt == '0) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency register read for mfhi/mflo; old value is returned while busy.
    always_comb begin
        rdata = '0;
        if (op == OP_MFHI)      rdata = hi_q;
        else if (op == OP_MFLO) rdata = lo_q;
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with hand-computed HI/LO and busy-length expectations.
// Latency: checks MUL_CYCLES=5 / DIV_CYCLES=10 busy windows and 1-cycle MT* writes.
// Backpressure: never starts while busy; an assertion flags it. Expectations follow MDU_MADD_EN.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         cancel;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy;
    logic [W-1:0] rdata, hi, lo;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .rdata  (rdata),
        .hi     (hi),
        .lo     (lo)
    );

    // Hazard controller contract: no un-cancelled start while a long op is in flight.
    always @(posedge clk) begin
        if (reset && start && !cancel)
            assert (!busy) else $error("start issued while busy");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = OP_NONE; a = '0; b = '0;
    endtask

    // Counts samples with busy high; bounded so a stuck busy cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        reset = 1'b0; start = 1'b0; cancel = 1'b0; op = OP_NONE; a = '0; b = '0;
        tick(2);
        op = OP_MFHI; #1;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_rdata", rdata, 0);
        op = OP_NONE;
        reset = 1'b1;
        tick();

        // MULT -3 * 7 = -21
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        op = OP_MFLO; #1;
        check("mult_rdata_old", rdata, 0);
        op = OP_NONE;
        wait_idle(nb);
        check("mult_busy_len", nb, 5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        op = OP_MFHI; #1; check("mfhi", rdata, 32'hFFFF_FFFF);
        op = OP_MFLO; #1; check("mflo", rdata, 32'hFFFF_FFEB);
        op = OP_NONE; #1; check("rdata_none", rdata, 0);

        // DIV -7 / 2 -> q=-3, r=-1
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(nb);
        check("div_busy_len", nb, 10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // MTHI/MTLO then divide by zero leaves them intact
        issue(OP_MTHI, 32'h11, 32'd0);
        check("mthi_hi", hi, 32'h11);
        check("mthi_busy", busy, 0);
        issue(OP_MTLO, 32'h22, 32'd0);
        check("mtlo_lo", lo, 32'h22);
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_idle(nb);
        check("dz_busy_len", nb, 10);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);

        // cancel suppresses a same-cycle MTHI
        start = 1'b1; op = OP_MTHI; a = 32'h99; cancel = 1'b1;
        tick();
        start = 1'b0; op = OP_NONE; a = '0; cancel = 1'b0;
        check("mthi_cancel_hi", hi, 32'h11);

        // Signed MIN / -1 and a positive / negative case
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(nb);
        check("minneg1_lo", lo, 32'h8000_0000);
        check("minneg1_hi", hi, 0);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle(nb);
        check("div7n2_lo", lo, 32'hFFFF_FFFD);
        check("div7n2_hi", hi, 32'd1);

        // MULTU max*max cancelled in busy cycle 3
        issue(OP_MTHI, 32'hAAAA, 32'd0);
        issue(OP_MTLO, 32'h5555, 32'd0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick(2);
        check("cancel_pre_busy", busy, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        check("cancel_hi", hi, 32'hAAAA);
        check("cancel_lo", lo, 32'h5555);
        issue(OP_MTLO, 32'h77, 32'd0);
        check("post_cancel_mtlo", lo, 32'h77);
        tick(8);
        check("no_late_hi", hi, 32'hAAAA);

        // cancel on the completing edge wins
        issue(OP_MULT, 32'd5, 32'd5);
        tick(4);
        check("last_cycle_busy", busy, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("last_cancel_busy", busy, 0);
        check("last_cancel_lo", lo, 32'h77);
        check("last_cancel_hi", hi, 32'hAAAA);

        // DIVU then back-to-back MULTU in the first idle cycle
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle(nb);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        issue(OP_MULTU, 32'd3, 32'd4);
        check("b2b_busy", busy, 1);
        wait_idle(nb);
        check("b2b_len", nb, 5);
        check("b2b_lo", lo, 32'd12);
        check("b2b_hi", hi, 0);

        // Asynchronous reset in DIV busy cycle 6
        issue(OP_DIV, 32'd1000, 32'd3);
        tick(5);
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        tick(2);
        reset = 1'b1;
        tick(15);
        check("arst_late_busy", busy, 0);
        check("arst_late_lo", lo, 0);

        // Accumulate ops: present only in the MDU_MADD_EN build
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_idle(nb);
        check("maddu_len", nb, 5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 0);
        issue(OP_MSUB, 32'd2, 32'hFFFF_FFFF);
        wait_idle(nb);
        check("msub_hi", hi, 32'd1);
        check("msub_lo", lo, 32'd2);
`else
        check("maddu_off_busy", busy, 0);
        tick(6);
        check("maddu_off_busy_late", busy, 0);
        check("maddu_off_hi", hi, 0);
        check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
